// File: rtl/pipelined_rca_adder_if.sv
// Handshake bundle for pipelined_rca_adder: upstream operands and downstream result.
// Carries the ovf result bit only when ADDER_OVF_EN is defined.
interface pipelined_rca_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef ADDER_OVF_EN
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
`else
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );
`endif
endinterface

// File: rtl/pipelined_rca_adder.sv
// Pipelined ripple-carry adder: {cout,sum} = a + b + cin, carry chain cut into STAGES registered slices.
// Optional signed-overflow output enabled by defining ADDER_OVF_EN.
module pipelined_rca_adder #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 4
) (
  input logic                 clk,
  input logic                 rst,
  pipelined_rca_adder_if.slave bus
);
  localparam int CHUNK = WIDTH / STAGES;
  localparam int LAST  = STAGES - 1;

  logic                           en;
  logic [STAGES-1:0]              vld_q;
  logic [STAGES-1:0]              cy_q;
  logic [STAGES-1:0]              v_src;
  logic [STAGES-1:0]              c_src;
  logic [STAGES-1:0]              cy_d;
  logic [STAGES-1:0][WIDTH-1:0]   a_q;
  logic [STAGES-1:0][WIDTH-1:0]   b_q;
  logic [STAGES-1:0][WIDTH-1:0]   sum_q;
  logic [STAGES-1:0][WIDTH-1:0]   a_src;
  logic [STAGES-1:0][WIDTH-1:0]   b_src;
  logic [STAGES-1:0][WIDTH-1:0]   s_src;
  logic [STAGES-1:0][WIDTH-1:0]   sum_d;

  // Whole pipe moves together; only a stalled valid result at the tail blocks it.
  assign en           = !vld_q[LAST] || bus.out_ready;
  assign bus.in_ready = en;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CHUNK:0]   slice;
    logic [WIDTH-1:0] s_ins;

    if (k == 0) begin : g_first
      assign v_src[k] = bus.in_valid;
      assign a_src[k] = bus.a;
      assign b_src[k] = bus.b;
      assign c_src[k] = bus.cin;
      assign s_src[k] = '0;
    end else begin : g_next
      assign v_src[k] = vld_q[k-1];
      assign a_src[k] = a_q[k-1];
      assign b_src[k] = b_q[k-1];
      assign c_src[k] = cy_q[k-1];
      assign s_src[k] = sum_q[k-1];
    end

    assign slice = {1'b0, a_src[k][k*CHUNK +: CHUNK]}
                 + {1'b0, b_src[k][k*CHUNK +: CHUNK]}
                 + {{CHUNK{1'b0}}, c_src[k]};

    always_comb begin
      s_ins = s_src[k];
      s_ins[k*CHUNK +: CHUNK] = slice[CHUNK-1:0];
    end

    assign sum_d[k] = s_ins;
    assign cy_d[k]  = slice[CHUNK];
  end

  // Data registers only load behind a valid token so bubbles leave the last result untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      cy_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      sum_q <= '0;
    end else if (en) begin
      vld_q <= v_src;
      for (int k = 0; k < STAGES; k++) begin
        if (v_src[k]) begin
          a_q[k]   <= a_src[k];
          b_q[k]   <= b_src[k];
          sum_q[k] <= sum_d[k];
          cy_q[k]  <= cy_d[k];
        end
      end
    end
  end

  assign bus.out_valid = vld_q[LAST];
  assign bus.sum       = sum_q[LAST];
  assign bus.cout      = cy_q[LAST];

`ifdef ADDER_OVF_EN
  logic ovf_q;
  logic ovf_d;

  assign ovf_d = (a_src[LAST][WIDTH-1] == b_src[LAST][WIDTH-1])
              && (sum_d[LAST][WIDTH-1] != a_src[LAST][WIDTH-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (en && v_src[LAST]) begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.ovf = ovf_q;
`endif

  // Tail operand copies have no consumer; they exist only to keep the stage structure uniform.
  logic unused_pass;
  assign unused_pass = ^{a_q[LAST], b_q[LAST]};

endmodule
